// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared types and constants for the seven-segment display path.
//   seg_t      : segment vector {g,f,e,d,c,b,a}
//   SEG_OFF    : all segments dark, active-high form
//   HEX_FONT   : 16-entry active-high hex font (0..9, A, b, C, d, E, F)
//   state_t    : slot phase of the multiplexer (BLANK / SHOW)
//   apply_polarity : converts an active-high segment vector to pin polarity
// ---------------------------------------------------------------------------
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'b0000000;

  // Index is the nibble value; bit 6 is segment g, bit 0 is segment a.
  localparam seg_t HEX_FONT [0:15] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111,  // 9
    7'b1110111,  // A
    7'b1111100,  // b
    7'b0111001,  // C
    7'b1011110,  // d
    7'b1111001,  // E
    7'b1110001   // F
  };

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Active-high segment pattern to the level seen on the pins.
  function automatic seg_t apply_polarity(input seg_t s, input logic active_low);
    return active_low ? ~s : s;
  endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// ---------------------------------------------------------------------------
// hex_seg_decoder
// Purely combinational hex nibble to seven-segment decoder. Usable on its own
// for a single-digit display or behind a digit multiplexer.
// Ports:
//   nibble     in  4  hex value to display
//   active_low in  1  1 = invert the pattern for active-low segment lines
//   seg        out 7  {g,f,e,d,c,b,a} at pin polarity
// ---------------------------------------------------------------------------
module hex_seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       active_low,
  output seg_t       seg
);

  seg_t font_bits;

  always_comb begin
    font_bits = HEX_FONT[nibble];
    seg       = apply_polarity(font_bits, active_low);
  end

endmodule

// File: rtl/seg_mux_display.sv
// ---------------------------------------------------------------------------
// seg_mux_display
// Time-multiplexed driver for NUM_DIGITS seven-segment digits sharing one
// segment bus. Each digit owns a slot of REFRESH_DIV cycles; the first
// BLANK_CYCLES of every slot keep all anodes off so the previous digit's
// pattern cannot ghost onto the next one. New content is captured into a
// pending register by load and only copied to the displayed (shadow)
// register at the frame wrap, so a frame never mixes old and new digits.
// Ports:
//   clk        in  1             system clock
//   reset      in  1             synchronous, active-high
//   digits_in  in  4*NUM_DIGITS  hex nibbles, digit i = digits_in[4i+3:4i]
//   digit_en   in  NUM_DIGITS    per-digit display enable
//   load       in  1             capture digits_in/digit_en into pending
//   seg        out 7             {g,f,e,d,c,b,a}
//   anode      out NUM_DIGITS    one-hot digit select
//   frame_done out 1             one-cycle pulse in the first cycle of a frame
// ---------------------------------------------------------------------------
module seg_mux_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int REFRESH_DIV    = 24000,
  parameter int BLANK_CYCLES   = 200,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // Digit-select arrays are padded to a power of two so idx can index them
  // over its full range without an out-of-bounds select.
  localparam int SEL_N = 1 << IDX_W;

  localparam logic SEG_LOW = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_LOW = (DIG_ACTIVE_LOW != 0);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------
  // Slot sequencer
  // ---------------------------------------------------------------------
  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              wrap;
  logic              frame_done_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= BLANK;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      frame_done_reg <= wrap;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    idx_next   = idx_reg;
    wrap       = 1'b0;
    case (state_reg)
      BLANK: begin
        if (cnt_reg == BLANK_LAST) begin
          state_next = SHOW;
        end
      end
      SHOW: begin
        if (cnt_reg == SLOT_LAST) begin
          state_next = BLANK;
          cnt_next   = '0;
          // The end of the last digit's slot is the frame boundary.
          if (idx_reg == IDX_LAST) begin
            idx_next = '0;
            wrap     = 1'b1;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      default: begin
        state_next = BLANK;
        cnt_next   = '0;
        idx_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Pending / shadow content registers
  // ---------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] pending_digits_reg;
  logic [NUM_DIGITS-1:0]   pending_en_reg;
  logic [4*NUM_DIGITS-1:0] shadow_digits_reg;
  logic [NUM_DIGITS-1:0]   shadow_en_reg;

  // Shadow copies the pre-edge pending value, so a load landing on the wrap
  // edge is held back until the following frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_digits_reg <= '0;
      pending_en_reg     <= '1;
      shadow_digits_reg  <= '0;
      shadow_en_reg      <= '1;
    end else begin
      if (load) begin
        pending_digits_reg <= digits_in;
        pending_en_reg     <= digit_en;
      end
      if (wrap) begin
        shadow_digits_reg <= pending_digits_reg;
        shadow_en_reg     <= pending_en_reg;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output mux: everything below depends on registered state only.
  // ---------------------------------------------------------------------
  logic [3:0]       nib_sel [SEL_N];
  logic [SEL_N-1:0] en_sel;

  for (genvar gi = 0; gi < SEL_N; gi++) begin : g_sel
    if (gi < NUM_DIGITS) begin : g_real
      assign nib_sel[gi] = shadow_digits_reg[4*gi +: 4];
      assign en_sel[gi]  = shadow_en_reg[gi];
    end else begin : g_pad
      assign nib_sel[gi] = 4'h0;
      assign en_sel[gi]  = 1'b0;
    end
  end

  logic [3:0] cur_nibble;
  logic       showing;
  seg_t       dec_seg;

  assign cur_nibble = nib_sel[idx_reg];
  // A disabled digit still consumes its slot, it just stays dark.
  assign showing    = (state_reg == SHOW) && en_sel[idx_reg];

  hex_seg_decoder u_dec (
    .nibble     (cur_nibble),
    .active_low (SEG_LOW),
    .seg        (dec_seg)
  );

  assign seg = showing ? dec_seg : apply_polarity(SEG_OFF, SEG_LOW);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
    assign anode[gi] = (showing && (idx_reg == IDX_W'(gi))) ^ DIG_LOW;
  end

  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_mux_display.sv
// ---------------------------------------------------------------------------
// tb_seg_mux_display
// Four-digit instance (REFRESH_DIV=8, BLANK_CYCLES=2, both polarities
// active-low). The stimulus process issues loads from a directed table and,
// at every frame start, pushes the expected per-slot anode/seg pattern into
// a queue. A separate monitor samples every cycle on the falling edge,
// checks blank cycles and frame_done against fixed timing, and pops one
// slot record at the end of each slot's SHOW window.
// ---------------------------------------------------------------------------
module tb_seg_mux_display;

  localparam int ND  = 4;
  localparam int RD  = 8;
  localparam int BC  = 2;
  localparam int FRM = ND * RD;

  logic          clk;
  logic          reset;
  logic [15:0]   digits_in;
  logic [3:0]    digit_en;
  logic          load;
  logic [6:0]    seg;
  logic [3:0]    anode;
  logic          frame_done;

  seg_mux_display #(
    .NUM_DIGITS     (ND),
    .REFRESH_DIV    (RD),
    .BLANK_CYCLES   (BC),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .digit_en   (digit_en),
    .load       (load),
    .seg        (seg),
    .anode      (anode),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
  } slot_t;

  slot_t       exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          mon_cycles = 0;
  event        go;

  logic [15:0] pend_d, shad_d;
  logic [3:0]  pend_e, shad_e;

  // Load schedule, cycle numbers counted from reset release.
  int          load_cyc [6] = '{5, 42, 67, 127, 172, 193};
  logic [15:0] load_d   [6] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFDEC, 16'hFFFF, 16'hE5E5};
  logic [3:0]  load_e   [6] = '{4'b1111, 4'b1111, 4'b1111, 4'b0101, 4'b1111, 4'b0110};

  // Hand-inverted font for active-low segment lines, {g..a}.
  function automatic logic [6:0] font_al(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic push_frame();
    slot_t s;
    for (int d = 0; d < ND; d++) begin
      if (shad_e[d]) begin
        s.anode = ~(4'b0001 << d);
        s.seg   = font_al(shad_d[4*d +: 4]);
      end else begin
        s.anode = 4'b1111;
        s.seg   = 7'b1111111;
      end
      exp_q.push_back(s);
    end
  endtask

  task automatic chk(input string name, input int t, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%b exp=%b", name, t, got, exp);
    end
  endtask

  task automatic check_cycle(input int t);
    int    pos;
    slot_t s;
    pos = t % RD;
    chk("frame_done", t, {6'b0, frame_done}, {6'b0, (t > 0) && (t % FRM == 0)});
    if (pos < BC) begin
      chk("blank_anode", t, {3'b0, anode}, 7'b0001111);
      chk("blank_seg", t, seg, 7'b1111111);
    end else if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL slot_queue t=%0d got=empty exp=record", t);
    end else begin
      s = exp_q[0];
      chk("show_anode", t, {3'b0, anode}, {3'b0, s.anode});
      chk("show_seg", t, seg, s.seg);
      if (pos == RD - 1) void'(exp_q.pop_front());
    end
  endtask

  // Monitor: one pass of mon_cycles checks per go event.
  initial begin
    forever begin
      @(go);
      for (int t = 0; t < mon_cycles; t++) begin
        if (t > 0) @(negedge clk);
        check_cycle(t);
      end
    end
  end

  // Drives cycles 0..ncyc-2 and ends at the falling edge of cycle ncyc-1.
  task automatic run_phase(input int ncyc, input bit with_loads);
    logic        ld;
    logic [15:0] ld_d;
    logic [3:0]  ld_e;
    for (int g = 0; g < ncyc - 1; g++) begin
      ld = 1'b0;
      ld_d = 16'h0;
      ld_e = 4'h0;
      if (with_loads) begin
        for (int k = 0; k < 6; k++) begin
          if (load_cyc[k] == g) begin
            ld = 1'b1;
            ld_d = load_d[k];
            ld_e = load_e[k];
          end
        end
      end
      load = ld;
      digits_in = ld_d;
      digit_en = ld_e;
      @(posedge clk);
      if (g % FRM == FRM - 1) begin
        shad_d = pend_d;
        shad_e = pend_e;
      end
      if (ld) begin
        pend_d = ld_d;
        pend_e = ld_e;
      end
      if (g % FRM == FRM - 1) push_frame();
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic reset_model();
    pend_d = 16'h0;
    pend_e = 4'hF;
    shad_d = 16'h0;
    shad_e = 4'hF;
    exp_q.delete();
    push_frame();
  endtask

  initial begin
    reset = 1'b1;
    load = 1'b0;
    digits_in = 16'h0;
    digit_en = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_anode", i, {3'b0, anode}, 7'b0001111);
      chk("rst_seg", i, seg, 7'b1111111);
      chk("rst_frame_done", i, {6'b0, frame_done}, 7'b0);
    end

    // Phase 1: scan order, font coverage, load at wrap, enable mask,
    // tear-free update; ends at cycle 244 = frame 7, SHOW of digit 2.
    reset = 1'b0;
    reset_model();
    mon_cycles = 245;
    -> go;
    run_phase(245, 1'b1);

    // Reset mid-SHOW: outputs inactive from the next cycle on.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("midrst_anode", i, {3'b0, anode}, 7'b0001111);
      chk("midrst_seg", i, seg, 7'b1111111);
      chk("midrst_frame_done", i, {6'b0, frame_done}, 7'b0);
    end

    // Phase 2: restart from digit 0 with reset pending/shadow contents.
    reset = 1'b0;
    reset_model();
    mon_cycles = 65;
    -> go;
    run_phase(65, 1'b0);
    @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t got=running exp=finished", $time);
    $fatal(1, "timeout");
  end

endmodule
